led_trail_pwm: RTL and testbench

Downstream consumer of the LED ping-pong shifter's 8-bit `dataOut` pattern; drives the 8 board LEDs. Each LED lit by the pattern is shown at full brightness. When the pattern bit clears, the LED fades out linearly through PWM, which gives the scanning light a comet-style trail. The block contains one shared PWM counter, one shared decay prescaler and eight per-channel brightness registers.

---
 rtl/led_trail_pwm.sv | 84 ++++++++
 tb/tb_led_trail_pwm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/led_trail_pwm.sv
// LED comet-trail driver: full brightness while lit, then a linear PWM fade-out.
// Latency: pattern to led_out is 2 cycles; no backpressure, and en=0 freezes the state and blanks the outputs.
// Defining LED_TRAIL_GAMMA_EN squares the duty value so the fade looks smoother to the eye.
module led_trail_pwm #(
    parameter int PWM_BITS  = 4,
    parameter int DECAY_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] pattern_in,
    output logic [7:0] led_out,
    output logic       frame_tick
);
    localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [DW-1:0]       DEC_LAST = DW'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [DW-1:0]       r_decay_cnt;
    logic [PWM_BITS-1:0] r_level [8];
    logic [7:0]          r_led_out;
    logic                r_frame_tick;

    logic                w_wrap;
    logic                w_decay_tick;
    logic [PWM_BITS-1:0] w_duty [8];
    logic [7:0]          w_led_nxt;
`ifdef LED_TRAIL_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_sq [8];
`endif

    always_comb begin
        w_wrap       = (r_pwm_cnt == MAX) && en;
        w_decay_tick = w_wrap && (r_decay_cnt == DEC_LAST);
    end

    // MAX is forced solid on: a duty compare alone would leave a one-cycle gap per period.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
`ifdef LED_TRAIL_GAMMA_EN
            w_sq[i]   = {{PWM_BITS{1'b0}}, r_level[i]} * {{PWM_BITS{1'b0}}, r_level[i]};
            w_duty[i] = w_sq[i][2*PWM_BITS-1:PWM_BITS];
`else
            w_duty[i] = r_level[i];
`endif
            w_led_nxt[i] = en && ((r_level[i] == MAX) || (w_duty[i] > r_pwm_cnt));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt    <= '0;
            r_decay_cnt  <= '0;
            r_led_out    <= '0;
            r_frame_tick <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            r_led_out    <= w_led_nxt;
            r_frame_tick <= w_wrap;
            if (en) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            if (w_decay_tick) begin
                r_decay_cnt <= '0;
            end else if (w_wrap) begin
                r_decay_cnt <= r_decay_cnt + 1'b1;
            end
            // A load wins over a decrement that lands in the same cycle.
            for (int i = 0; i < 8; i++) begin
                if (en && pattern_in[i]) begin
                    r_level[i] <= MAX;
                end else if (w_decay_tick && (r_level[i] != '0)) begin
                    r_level[i] <= r_level[i] - 1'b1;
                end
            end
        end
    end

    assign led_out    = r_led_out;
    assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm (PWM_BITS=4, DECAY_DIV=2): a run-count model checks the outputs every cycle,
// directed windows pin the fade, collision, reset and enable behaviour with literal values.
module tb_led_trail_pwm;
    localparam int PB   = 4;
    localparam int DD   = 2;
    localparam int P    = 16;
    localparam int MAXL = 15;
    localparam int T    = P * DD;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] pattern_in;
    logic [7:0] led_out;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_trail_pwm #(.PWM_BITS(PB), .DECAY_DIV(DD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pattern_in(pattern_in),
        .led_out   (led_out),
        .frame_tick(frame_tick)
    );

    function automatic int duty_of(input int l);
`ifdef LED_TRAIL_GAMMA_EN
        return (l * l) >> PB;
`else
        return l;
`endif
    endfunction

    // Level after 'run' enabled cycles, given the run index of the last load (-1 = never).
    // Decay ticks fall on run indices k with k % T == T-1.
    function automatic int lvl_of(input int last, input int run);
        int t;
        if (last < 0) return 0;
        t = run / T - (last + 1) / T;
        if (t >= MAXL) return 0;
        return MAXL - t;
    endfunction

    int         m_run;
    int         m_last [8];
    logic [7:0] exp_led;
    logic       exp_ft;

    always @(posedge clk) begin
        if (rst) begin
            m_run   <= 0;
            exp_led <= '0;
            exp_ft  <= 1'b0;
            for (int i = 0; i < 8; i++) m_last[i] <= -1;
        end else if (!en) begin
            exp_led <= '0;
            exp_ft  <= 1'b0;
        end else begin
            exp_ft <= ((m_run % P) == P - 1);
            for (int i = 0; i < 8; i++) begin
                exp_led[i] <= (lvl_of(m_last[i], m_run) == MAXL) ||
                              (duty_of(lvl_of(m_last[i], m_run)) > (m_run % P));
                if (pattern_in[i]) m_last[i] <= m_run;
            end
            m_run <= m_run + 1;
        end
    end

    bit chk_on = 1'b1;
    always @(negedge clk) begin
        if (chk_on) begin
            total = total + 1;
            if (led_out !== exp_led || frame_tick !== exp_ft) begin
                bad = bad + 1;
                $display("FAIL model_cmp t=%0t led_out=%h frame_tick=%b expected led_out=%h frame_tick=%b",
                         $time, led_out, frame_tick, exp_led, exp_ft);
            end
        end
    end

    task automatic check(input string name, input int act, input int expv);
        total = total + 1;
        if (act != expv) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic cyc(input logic [7:0] p);
        pattern_in = p;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        en         = 1'b1;
        pattern_in = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("reset_led", int'(led_out), 0);
            check("reset_ft", int'(frame_tick), 0);
        end
        rst = 1'b0;
    endtask

    // Counts led_out[ch] high samples over 16 cycles with no new load; also checks the trailing frame_tick.
    task automatic window(input string name, input int ch, input int expv);
        int hi;
        hi = 0;
        repeat (16) begin
            cyc(8'h00);
            hi += int'(led_out[ch]);
        end
        check(name, hi, expv);
        check({name, "_ft"}, int'(frame_tick), 1);
    endtask

    initial begin
        int n;
        int lv;
        rst        = 1'b1;
        en         = 1'b1;
        pattern_in = 8'hFF;

        // Reset, then idle: dark LEDs, frame_tick every 16 cycles.
        do_reset();
        n = 0;
        lv = 0;
        repeat (48) begin
            cyc(8'h00);
            n  += int'(frame_tick);
            lv += (led_out != 8'h00) ? 1 : 0;
        end
        check("idle_ft_count", n, 3);
        check("idle_led_dark", lv, 0);

        // Held pattern: solid on from the second sample onwards.
        do_reset();
        cyc(8'h01);
        check("hold_first", int'(led_out), 0);
        n = 0;
        repeat (19) begin
            cyc(8'h01);
            n += (led_out == 8'h01) ? 1 : 0;
        end
        check("hold_solid", n, 19);

        // Fade of channel 7 after a one-cycle load.
        do_reset();
        cyc(8'h80);
        repeat (15) cyc(8'h00);
        check("fade_ft_align", int'(frame_tick), 1);
        for (int w = 0; w < 32; w++) begin
            lv = MAXL - (w + 1) / 2;
            if (lv < 0) lv = 0;
            window("fade_win", 7, (lv == MAXL) ? 16 : duty_of(lv));
        end

        // Load in the exact decay-tick cycle keeps the level at MAX.
        do_reset();
        cyc(8'h08);
        repeat (62) cyc(8'h00);
        cyc(8'h08);
        window("collision_solid", 3, 16);
        window("collision_after", 3, 16);

        // Reset mid-fade at level 7.
        do_reset();
        cyc(8'h20);
        repeat (255) cyc(8'h00);
        window("pre_reset_l7", 5, duty_of(7));
        rst = 1'b1;
        @(negedge clk);
        check("midfade_reset_led", int'(led_out), 0);
        rst = 1'b0;
        n = 0;
        repeat (64) begin
            cyc(8'h00);
            n += (led_out != 8'h00) ? 1 : 0;
        end
        check("no_residual_trail", n, 0);

        // Disable at level 9 on a period boundary, then resume.
        do_reset();
        cyc(8'h04);
        repeat (191) cyc(8'h00);
        window("pre_dis_l9", 2, duty_of(9));
        en = 1'b0;
        n = 0;
        repeat (100) begin
            cyc(8'h04);
            n += (led_out != 8'h00 || frame_tick) ? 1 : 0;
        end
        check("disabled_dark", n, 0);
        en = 1'b1;
        window("resume_l9", 2, duty_of(9));
        window("resume_l8", 2, duty_of(8));

        // Random traffic against the model.
        repeat (3000) begin
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 7) == 0) cyc(8'($urandom));
            else cyc(8'h00);
        end
        rst = 1'b0;

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
